// File: rtl/usb_uart_arb_pkg.sv
// rtl/usb_uart_arb_pkg.sv - shared state encoding and sizing for the UART transmit arbiter
package usb_uart_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      FETCH = ST_FETCH,
      WRITE = ST_WRITE,
      GAP   = ST_GAP
   } arb_state_e;

   localparam int DEFAULT_TIMEOUT = 1024;

   function automatic int wd_width(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/usb_uart_tx_arbiter_rr_picker.sv
// rtl/usb_uart_tx_arbiter_rr_picker.sv - combinational round-robin one-hot selector
module rr_picker #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic [NUM_REQ-1:0]         pick,
   output logic [$clog2(NUM_REQ)-1:0] pick_idx
);

   localparam int IDX_W = $clog2(NUM_REQ);

   int   cand;
   logic found;

   // Search starts one past the previous owner so every requester gets a turn.
   always_comb begin
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      cand     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(last_grant) + k) % NUM_REQ;
         if (!found && req[cand]) begin
            found       = 1'b1;
            pick[cand]  = 1'b1;
            pick_idx    = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/usb_uart_tx_arbiter.sv
// rtl/usb_uart_tx_arbiter.sv - message-granular round-robin arbiter for the usb_uart transmit port
module usb_uart_tx_arbiter
   import usb_uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                 clk_48mhz,
   input  logic                 resetn,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 timeout_pulse,
   output logic                 uart_we,
   output logic [7:0]           uart_di,
   input  logic                 uart_wait
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = wd_width(TIMEOUT);
   localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LG_INIT = IDX_W'(NUM_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   lg_q, lg_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic               last_q, last_d;
   logic               we_q, we_d;
   logic [7:0]         di_q, di_d;
   logic               to_q, to_d;

   logic [NUM_REQ-1:0] pick;
   logic [IDX_W-1:0]   pick_idx;
   logic               accept;
   logic [7:0]         sel_data;
   logic               sel_last;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req        (req_valid),
      .last_grant (lg_q),
      .pick       (pick),
      .pick_idx   (pick_idx)
   );

   assign req_ready     = (state_q == FETCH) ? grant_q : '0;
   assign accept        = |(req_valid & req_ready);
   assign sel_data      = req_data[{gidx_q, 3'b000} +: 8];
   assign sel_last      = req_last[gidx_q];
   assign grant         = grant_q;
   assign busy          = |grant_q;
   assign timeout_pulse = to_q;
   assign uart_we       = we_q;
   assign uart_di       = di_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      lg_d    = lg_q;
      wd_d    = wd_q;
      last_d  = last_q;
      we_d    = we_q;
      di_d    = di_q;
      to_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               grant_d = pick;
               gidx_d  = pick_idx;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (accept) begin
               di_d    = sel_data;
               last_d  = sel_last;
               we_d    = 1'b1;
               wd_d    = '0;
               state_d = WRITE;
            end else if (wd_q == WD_MAX) begin
               // Stalled owner loses the port; it is skipped first on the next pick.
               to_d    = 1'b1;
               grant_d = '0;
               lg_d    = gidx_q;
               wd_d    = '0;
               state_d = IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         WRITE: begin
            if (!uart_wait) begin
               we_d    = 1'b0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (last_q) begin
               lg_d    = gidx_q;
               grant_d = '0;
               last_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_48mhz) begin
      if (!resetn) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         lg_q    <= LG_INIT;
         wd_q    <= '0;
         last_q  <= 1'b0;
         we_q    <= 1'b0;
         di_q    <= 8'h00;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         lg_q    <= lg_d;
         wd_q    <= wd_d;
         last_q  <= last_d;
         we_q    <= we_d;
         di_q    <= di_d;
         to_q    <= to_d;
      end
   end

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// tb/tb_usb_uart_tx_arbiter.sv - directed vector bench for the UART transmit arbiter
module tb_usb_uart_tx_arbiter;

   localparam int NR = 4;

   logic          clk_48mhz = 1'b0;
   logic          resetn;
   logic [NR-1:0] req_valid;
   logic [8*NR-1:0] req_data;
   logic [NR-1:0] req_last;
   logic [NR-1:0] req_ready;
   logic [NR-1:0] grant;
   logic          busy;
   logic          timeout_pulse;
   logic          uart_we;
   logic [7:0]    uart_di;
   logic          uart_wait;

   usb_uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(8)) dut (
      .clk_48mhz     (clk_48mhz),
      .resetn        (resetn),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .grant         (grant),
      .busy          (busy),
      .timeout_pulse (timeout_pulse),
      .uart_we       (uart_we),
      .uart_di       (uart_di),
      .uart_wait     (uart_wait)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
      logic       l;
      logic [3:0] g;
      logic [3:0] r;
      logic       we;
      logic [7:0] di;
   } vec_t;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } ent_t;

   vec_t       tbl [12];
   ent_t       qb [NR][16];
   int         qh [NR];
   int         qt [NR];
   logic [NR-1:0] en;
   int         cyc;
   int         wr_cnt;
   logic [7:0] wr_dat [64];
   int         wr_cyc [64];
   logic [NR-1:0] wr_own [64];
   logic [7:0] exp_d [4];
   int         exp_o [4];
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]      = en[i] && (qh[i] < qt[i]);
         req_data[8*i +: 8] = req_valid[i] ? qb[i][qh[i]].d : 8'h00;
         req_last[i]       = req_valid[i] ? qb[i][qh[i]].l : 1'b0;
      end
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic l);
      qb[i][qt[i]] = '{d, l};
      qt[i]++;
   endtask

   task automatic tick();
      logic [NR-1:0] acc;
      acc = req_valid & req_ready;
      if (uart_we && !uart_wait && wr_cnt < 64) begin
         wr_dat[wr_cnt] = uart_di;
         wr_cyc[wr_cnt] = cyc;
         wr_own[wr_cnt] = grant;
         wr_cnt++;
      end
      @(posedge clk_48mhz);
      #1;
      cyc++;
      for (int i = 0; i < NR; i++) if (acc[i]) qh[i]++;
      drive();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      uart_wait = 1'b0;
      en        = '0;
      for (int i = 0; i < NR; i++) begin qh[i] = 0; qt[i] = 0; end
      drive();
      @(posedge clk_48mhz);
      #1;
      resetn = 1'b1;
      cyc    = 0;
      wr_cnt = 0;
   endtask

   task automatic check_log(input string nm, input int n);
      chk({nm, "_count"}, wr_cnt, n);
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s_data%0d", nm, k), wr_dat[k], exp_d[k]);
         chk($sformatf("%s_owner%0d", nm, k), wr_own[k], 1 << exp_o[k]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL sim_time_limit: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n, held, waited, tp_first, tp_cnt, rdy1;
      logic [NR-1:0] g12, g13, g11, r11;
      logic w11;

      tbl[0]  = '{1'b1, 8'h48, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 8'h48, 1'b0, 4'h1, 4'h1, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 8'h69, 1'b0, 4'h1, 4'h0, 1'b1, 8'h48};
      tbl[3]  = '{1'b1, 8'h69, 1'b0, 4'h1, 4'h0, 1'b0, 8'h48};
      tbl[4]  = '{1'b1, 8'h69, 1'b0, 4'h1, 4'h1, 1'b0, 8'h48};
      tbl[5]  = '{1'b1, 8'h0A, 1'b1, 4'h1, 4'h0, 1'b1, 8'h69};
      tbl[6]  = '{1'b1, 8'h0A, 1'b1, 4'h1, 4'h0, 1'b0, 8'h69};
      tbl[7]  = '{1'b1, 8'h0A, 1'b1, 4'h1, 4'h1, 1'b0, 8'h69};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 4'h1, 4'h0, 1'b1, 8'h0A};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 4'h1, 4'h0, 1'b0, 8'h0A};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 8'h0A};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 8'h0A};

      // Reset values
      do_reset();
      chk("rst_grant", grant, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_we", uart_we, 0);
      chk("rst_di", uart_di, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_pulse, 0);

      // Single requester "Hi\n", cycle-exact vectors
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("hi_grant_c%0d", k), grant, tbl[k].g);
         chk($sformatf("hi_ready_c%0d", k), req_ready, tbl[k].r);
         chk($sformatf("hi_we_c%0d", k), uart_we, tbl[k].we);
         chk($sformatf("hi_di_c%0d", k), uart_di, tbl[k].di);
         chk($sformatf("hi_busy_c%0d", k), busy, |tbl[k].g);
         chk($sformatf("hi_timeout_c%0d", k), timeout_pulse, 0);
         req_valid = {3'b000, tbl[k].v};
         req_data  = {24'h0, tbl[k].d};
         req_last  = {3'b000, tbl[k].l};
         @(posedge clk_48mhz);
         #1;
      end

      // Contention from reset: 0 then 2
      do_reset();
      push(0, "A", 1'b0); push(0, "B", 1'b1);
      push(2, "C", 1'b0); push(2, "D", 1'b1);
      en = 4'b1111; drive();
      run(20);
      exp_d = '{"A", "B", "C", "D"}; exp_o = '{0, 0, 2, 2};
      check_log("cont1", 4);
      chk("cont1_cyc0", wr_cyc[0], 2);
      chk("cont1_cyc1", wr_cyc[1], 5);
      chk("cont1_cyc2", wr_cyc[2], 9);
      chk("cont1_cyc3", wr_cyc[3], 12);

      // Pointer wrap: last owner 2, requesters 0 and 3 -> 3 then 0
      wr_cnt = 0;
      push(0, "E", 1'b0); push(0, "F", 1'b1);
      push(3, "G", 1'b0); push(3, "H", 1'b1);
      drive();
      run(20);
      exp_d = '{"G", "H", "E", "F"}; exp_o = '{3, 3, 0, 0};
      check_log("cont2", 4);

      // Last owner 0, requesters 0 and 1 -> 1 then 0
      wr_cnt = 0;
      push(0, "I", 1'b0); push(0, "J", 1'b1);
      push(1, "K", 1'b0); push(1, "L", 1'b1);
      drive();
      run(20);
      exp_d = '{"K", "L", "I", "J"}; exp_o = '{1, 1, 0, 0};
      check_log("cont3", 4);

      // Back-pressure: five wait cycles on the second byte
      do_reset();
      push(0, "X", 1'b0); push(0, "Y", 1'b1);
      en = 4'b0001; drive();
      held = 0; waited = 0; g11 = '0; r11 = '1; w11 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         uart_wait = uart_we && (wr_cnt == 1) && (waited < 5);
         if (uart_wait) waited++;
         if (uart_we && uart_di == "Y") held++;
         if (cyc == 11) begin g11 = grant; r11 = req_ready; w11 = uart_we; end
         tick();
      end
      uart_wait = 1'b0;
      chk("bp_writes", wr_cnt, 2);
      chk("bp_cyc0", wr_cyc[0], 2);
      chk("bp_cyc1", wr_cyc[1], 10);
      chk("bp_held", held, 6);
      chk("bp_gap_we", w11, 0);
      chk("bp_gap_ready", r11, 0);
      chk("bp_gap_grant", g11, 4'b0001);

      // Watchdog: requester 1 stalls after one byte, requester 3 waiting
      do_reset();
      push(1, "Z", 1'b0);
      push(3, "W", 1'b1);
      en = 4'b0010; drive();
      tp_first = -1; tp_cnt = 0; rdy1 = 0; g12 = 'x; g13 = 'x;
      for (int k = 0; k < 24; k++) begin
         if (timeout_pulse) begin
            tp_cnt++;
            if (tp_first < 0) tp_first = cyc;
         end
         if (req_ready == 4'b0010) rdy1++;
         if (cyc == 12) g12 = grant;
         if (cyc == 13) g13 = grant;
         if (cyc == 2) begin en = 4'b1010; drive(); end
         tick();
      end
      chk("wd_pulse_cycle", tp_first, 12);
      chk("wd_pulse_count", tp_cnt, 1);
      chk("wd_fetch_cycles", rdy1, 9);
      chk("wd_grant_cleared", g12, 0);
      chk("wd_next_grant", g13, 4'b1000);
      exp_d = '{"Z", "W", 8'h00, 8'h00}; exp_o = '{1, 3, 0, 0};
      check_log("wd", 2);

      // Reset asserted during WRITE
      do_reset();
      push(2, "P", 1'b0); push(2, "Q", 1'b1);
      en = 4'b0100; drive();
      n = 0;
      while (!uart_we && n < 10) begin tick(); n++; end
      chk("mid_reached_write", uart_we, 1);
      resetn = 1'b0;
      tick();
      chk("mid_we", uart_we, 0);
      chk("mid_grant", grant, 0);
      chk("mid_ready", req_ready, 0);
      chk("mid_busy", busy, 0);
      chk("mid_di", uart_di, 0);
      resetn = 1'b1;
      for (int i = 0; i < NR; i++) begin qh[i] = 0; qt[i] = 0; end
      push(0, "R", 1'b1); push(2, "S", 1'b1);
      en = 4'b0101; drive();
      tick();
      chk("mid_first_grant", grant, 4'b0001);

      // Back-to-back single-byte messages from all requesters
      do_reset();
      for (int i = 0; i < NR; i++) push(i, 8'h30 + 8'(i), 1'b1);
      en = 4'b1111; drive();
      run(20);
      exp_d = '{"0", "1", "2", "3"}; exp_o = '{0, 1, 2, 3};
      check_log("single", 4);
      for (int k = 0; k < 4; k++) chk($sformatf("single_cyc%0d", k), wr_cyc[k], 2 + 4*k);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
